pop_ctrl: RTL and testbench
===========================

# pop_ctrl

Reader-side controller for the push/pop occupancy counter. It watches the counter's `count` output and issues single-cycle `pop` pulses, one per stored item, while a downstream consumer is ready. Pops are grouped into bursts of at most BURST items, followed by GAP idle cycles. The block never pops an empty counter. It sits between the occupancy counter (its `pop` drives the counter's `pop`) and the consumer logic.

## Interface
- CNT_W, 2, width of `count` from the occupancy counter
- BURST, 2, maximum pops per burst (1..2^CNT_W)
- GAP, 1, idle cycles between bursts (0..15)
- clk  input  1  system clock, rising edge
- rst  input  1  reset; one clock domain, asynchronous, active-low (`rst`=0 resets)
- count  input  CNT_W  current occupancy from the counter; updates on the clk edge after a push/pop
- out_ready  input  1  consumer can accept one item this cycle
- pop  output  1  one-cycle decrement request to the counter
- out_valid  output  1  item handed to the consumer this cycle; always equals `pop`
- busy  output  1  state is not IDLE
- pop_total  output  8  running count of pops issued; wraps 255 -> 0

## Operation
- States:
  - IDLE: waits for work.
  - POP: `pop` and `out_valid` are 1 for exactly this one cycle.
  - SETTLE: one cycle that lets the counter's registered `count` reflect the pop.
  - GAP: idle spacing between bursts.
- IDLE -> POP when `count` != 0 and `out_ready` = 1, sampled at the edge. Otherwise stay in IDLE.
- POP -> SETTLE unconditionally. On this edge `burst_cnt` increments and `pop_total` increments.
- SETTLE branches:
  - `burst_cnt` == BURST, or `count` == 0: go to GAP (or to IDLE if GAP = 0) and clear `burst_cnt`.
  - Otherwise, `out_ready` = 1: go to POP.
  - Otherwise: go to IDLE and keep `burst_cnt`. A stall does not end the burst.
- GAP: load `gap_cnt` = GAP on entry and decrement each cycle. Go to IDLE after GAP cycles.
- `pop` is decoded from registered state only (state == POP), so it is glitch-free.
- Never assert `pop` when the last sampled `count` was 0 (underflow guard).
- `out_ready` dropping while in POP does not cancel the pop; the handshake is sampled only at the IDLE/SETTLE decision edge.
- A push arriving while in GAP is ignored until IDLE.

## Timing
- Reset values: state = IDLE, `pop` = 0, `out_valid` = 0, `busy` = 0, `pop_total` = 0, `burst_cnt` = 0, `gap_cnt` = 0.
- Reset asserted mid-operation: `pop` drops immediately (asynchronous), with no partial pulse after release. The first decision is at the first edge with `rst` = 1.
- Latency: `count` != 0 and `out_ready` seen at edge k. `pop` is high from edge k to edge k+1. The counter decrements at edge k+1.
- Minimum pop spacing is 2 cycles (POP, SETTLE). Maximum throughput is 1 item per 2 cycles.
- Burst of N pops followed by the gap takes 2N + GAP cycles from the first POP to re-entering IDLE.
- Simultaneous push and pop at the counter are the counter's responsibility. This block only re-samples `count` in SETTLE.

## Structure
- Shared package holds:
  - the state enum: IDLE = 2'd0, POP = 2'd1, SETTLE = 2'd2, GAP = 2'd3
  - the `pop_total` width constant (8)
- Single module, no sub-modules. `burst_cnt` is $clog2(BURST+1) bits; `gap_cnt` is 4 bits.
- Bench instantiates `pop_ctrl` with the existing occupancy counter, wired `pop` -> `pop`.

## Test plan
- Reset, `count` = 0, `out_ready` = 1 for 20 cycles -> `pop` never 1, `busy` = 0, `pop_total` = 0.
- Three pushes (`count` = 3), `out_ready` = 1, BURST = 2, GAP = 1:
  - pops at edge offsets k, k+2, then GAP, then k+6
  - `count` goes 3 -> 2 -> 1 -> 0
  - `pop_total` = 3, final state IDLE
- `count` = 2, `out_ready` held 0 -> no pop. Raise `out_ready` -> `pop` exactly 1 cycle later, `out_valid` = `pop`.
- Drop `out_ready` in SETTLE after the first pop of a burst:
  - state goes to IDLE, `burst_cnt` = 1
  - on re-raise, one more pop, then GAP
- Assert `rst` = 0 during POP -> `pop` = 0 the same cycle, `pop_total` = 0. After release, resume from IDLE with no spurious pop.
- Issue 256 pops (drive `count` from a model) -> `pop_total` wraps to 0, and `count` never underflows below 0.

Source files
------------

// File: rtl/pop_ctrl_pkg.sv
// Shared definitions for the occupancy-counter reader controller.
package pop_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2,
        S_GAP    = 2'd3
    } state_e;

    localparam int TOTAL_W = 8;

endpackage

// File: rtl/pop_ctrl.sv
// Reader-side controller: issues single-cycle pops against the occupancy
// counter in bursts of up to BURST items separated by GAP idle cycles.
module pop_ctrl
    import pop_ctrl_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int BURST = 2,
    parameter int GAP   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   count,
    input  logic               out_ready,
    output logic               pop,
    output logic               out_valid,
    output logic               busy,
    output logic [TOTAL_W-1:0] pop_total
);

    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_L = BW'(BURST);
    localparam logic [3:0]    GAP_L   = 4'(GAP);

    state_e             state_q, state_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [3:0]         gap_q, gap_d;
    logic [TOTAL_W-1:0] total_q, total_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            burst_q <= '0;
            gap_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        total_d = total_q;
        case (state_q)
            S_IDLE: begin
                if (count != '0 && out_ready)
                    state_d = S_POP;
            end
            S_POP: begin
                state_d = S_SETTLE;
                burst_d = burst_q + 1'b1;
                total_d = total_q + 1'b1;
            end
            S_SETTLE: begin
                // count here already reflects the pop, so this is the underflow guard
                if (burst_q == BURST_L || count == '0) begin
                    burst_d = '0;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_L;
                    end
                end else if (out_ready) begin
                    state_d = S_POP;
                end else begin
                    // a stall keeps burst_cnt so the burst limit still applies
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q <= 4'd1) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop       = (state_q == S_POP);
    assign out_valid = pop;
    assign busy      = (state_q != S_IDLE);
    assign pop_total = total_q;

endmodule

// File: tb/tb_pop_ctrl.sv
// Bench for pop_ctrl wired to a small occupancy counter model.
module tb_pop_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cnt = 2'd0;
    logic       out_ready;
    logic       push;
    logic       pop, out_valid, busy;
    logic [7:0] pop_total;
    int         checks = 0;
    int         errors = 0;
    int         uflow  = 0;

    always #5 clk = ~clk;

    pop_ctrl #(.CNT_W(2), .BURST(2), .GAP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .count     (cnt),
        .out_ready (out_ready),
        .pop       (pop),
        .out_valid (out_valid),
        .busy      (busy),
        .pop_total (pop_total)
    );

    // occupancy counter: saturating push, pop, simultaneous push+pop holds
    always @(posedge clk) begin
        if (pop && cnt == 2'd0)
            uflow <= uflow + 1;
        if (push && !pop && cnt != 2'd3)
            cnt <= cnt + 2'd1;
        else if (!push && pop && cnt != 2'd0)
            cnt <= cnt - 2'd1;
    end

    typedef struct {
        logic       rdy;
        logic       psh;
        logic       e_pop;
        logic       e_busy;
        logic [1:0] e_cnt;
        logic [7:0] e_tot;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic p, input logic ep, input logic eb,
                       input logic [1:0] ec, input logic [7:0] et);
        vec_t v;
        v.rdy = r; v.psh = p; v.e_pop = ep; v.e_busy = eb; v.e_cnt = ec; v.e_tot = et;
        vecs.push_back(v);
    endtask

    initial begin
        int npops;
        bit done;
        rst       = 1'b0;
        out_ready = 1'b1;
        push      = 1'b0;

        // reset values while held in reset
        repeat (3) tick();
        chk("rst_pop", pop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_total", pop_total, 0);
        rst = 1'b1;

        // empty counter with consumer ready: never pop
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("empty_pop", pop, 0);
            chk("empty_busy", busy, 0);
            chk("empty_total", pop_total, 0);
        end

        // rdy psh | pop busy cnt total
        add(0,1, 0,0,1,0); add(0,1, 0,0,2,0); add(0,1, 0,0,3,0);
        add(1,0, 1,1,3,0); add(1,0, 0,1,2,1); add(1,0, 1,1,2,1);
        add(1,0, 0,1,1,2); add(1,0, 0,1,1,2); add(1,0, 0,0,1,2);
        add(1,0, 1,1,1,2); add(1,0, 0,1,0,3); add(1,0, 0,1,0,3);
        add(1,0, 0,0,0,3); add(1,0, 0,0,0,3);
        // count=2 with consumer held off, then released
        add(0,1, 0,0,1,3); add(0,1, 0,0,2,3); add(0,0, 0,0,2,3);
        add(0,0, 0,0,2,3); add(1,0, 1,1,2,3); add(1,0, 0,1,1,4);
        add(1,0, 1,1,1,4); add(1,0, 0,1,0,5); add(1,0, 0,1,0,5);
        add(1,0, 0,0,0,5);
        // stall in SETTLE keeps burst count; push during GAP waits for IDLE
        add(0,1, 0,0,1,5); add(0,1, 0,0,2,5); add(0,1, 0,0,3,5);
        add(1,0, 1,1,3,5); add(0,0, 0,1,2,6); add(0,0, 0,0,2,6);
        add(0,0, 0,0,2,6); add(1,0, 1,1,2,6); add(1,0, 0,1,1,7);
        add(1,0, 0,1,1,7); add(1,0, 0,0,1,7); add(1,0, 1,1,1,7);
        add(1,0, 0,1,0,8); add(1,0, 0,1,0,8); add(1,1, 0,0,1,8);
        add(1,0, 1,1,1,8); add(1,0, 0,1,0,9); add(1,0, 0,1,0,9);
        add(1,0, 0,0,0,9);

        foreach (vecs[i]) begin
            out_ready = vecs[i].rdy;
            push      = vecs[i].psh;
            tick();
            chk($sformatf("v%0d_pop", i), pop, vecs[i].e_pop);
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_pop);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_cnt", i), cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d_total", i), pop_total, vecs[i].e_tot);
        end

        // reset during POP
        out_ready = 1'b0;
        push      = 1'b1;
        repeat (3) tick();
        push      = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("pre_rst_pop", pop, 1);
        rst = 1'b0;
        #1;
        chk("async_pop", pop, 0);
        chk("async_busy", busy, 0);
        chk("async_total", pop_total, 0);
        tick();
        chk("rst_hold_cnt", cnt, 3);
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) begin
            tick();
            chk("post_rst_pop", pop, 0);
            chk("post_rst_busy", busy, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("resume_pop", pop, 1);
        chk("resume_cnt", cnt, 3);

        // 256 pops wrap pop_total
        rst = 1'b0;
        tick();
        rst       = 1'b1;
        push      = 1'b1;
        out_ready = 1'b1;
        npops     = 0;
        done      = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            tick();
            if (pop) begin
                npops++;
                if (npops == 256) begin
                    chk("total_255", pop_total, 255);
                    done = 1'b1;
                end
            end
        end
        chk("wrap_pops", npops, 256);
        push      = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("total_wrap", pop_total, 0);
        repeat (4) tick();
        chk("underflow", uflow, 0);
        chk("end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
